// File: rtl/hop_pkg.sv
// Shared constants and helpers for the per-stage reset-domain hop pipeline.
package hop_pkg;

    localparam int HOP_WIDTH       = 8;
    localparam int HOP_DEPTH       = 5;
    localparam int HOP_SYNC_STAGES = 2;
    localparam int DROP_W          = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Population count over up to 32 drop-event flags.
    function automatic logic [5:0] hop_popcount(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hop_rst_sync.sv
// Asynchronous-assert, synchronous-release reset synchroniser for one stage.
module hop_rst_sync
    import hop_pkg::*;
#(
    parameter int SYNC_STAGES = HOP_SYNC_STAGES
) (
    input  logic clock0,
    input  logic arst,
    output logic rs
);

    // Flops carry a "released" token so they all clear to 0 under reset.
    logic [SYNC_STAGES-1:0] rel_r;

    // Shift the release token through the chain; any reset source clears it at once.
    always_ff @(posedge clock0 or posedge arst) begin
        if (arst) begin
            rel_r <= '0;
        end else begin
            rel_r <= {rel_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rs = ~rel_r[SYNC_STAGES-1];

endmodule

// File: rtl/hop_pipe_rstdom.sv
// Valid/data pipeline whose stages each sit in their own reset domain, with a saturating drop counter.
module hop_pipe_rstdom
    import hop_pkg::*;
#(
    parameter int WIDTH       = HOP_WIDTH,
    parameter int DEPTH       = HOP_DEPTH,
    parameter int SYNC_STAGES = HOP_SYNC_STAGES
) (
    input  logic              clock0,
    input  logic              rst1,
    input  logic [DEPTH-1:0]  rst_stage,
    input  logic              en,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [DEPTH-1:0]  rst_busy,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [DEPTH-1:0]  stage_v_s;
    logic [WIDTH-1:0]  stage_d_s [DEPTH];
    logic [DEPTH-1:0]  drop_s;
    logic [31:0]       drop_ext_s;
    logic [DROP_W:0]   drop_sum_s;
    logic [DROP_W-1:0] drop_nxt_s;
    logic [DROP_W-1:0] drop_cnt_r;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             arst_s;
        logic             rs_s;
        logic             vin_s;
        logic [WIDTH-1:0] din_s;
        logic             v_r;
        logic [WIDTH-1:0] d_r;

        if (k == 0) begin : g_head
            assign vin_s = in_valid;
            assign din_s = in_data;
        end else begin : g_body
            assign vin_s = stage_v_s[k-1];
            assign din_s = stage_d_s[k-1];
        end

        assign arst_s = rst1 | rst_stage[k];

        hop_rst_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clock0(clock0),
            .arst  (arst_s),
            .rs    (rs_s)
        );

        // Stage register: cleared while its domain is in reset, shifts on enable, holds otherwise.
        always_ff @(posedge clock0 or posedge rs_s) begin
            if (rs_s) begin
                v_r <= 1'b0;
                d_r <= '0;
            end else if (en) begin
                v_r <= vin_s;
                d_r <= din_s;
            end
        end

        // A global reset discards everything anyway, so only local resets count as drops.
        assign drop_s[k]    = en & vin_s & rs_s & ~rst1;
        assign rst_busy[k]  = rs_s;
        assign stage_v_s[k] = v_r;
        assign stage_d_s[k] = d_r;
    end

    // Add this edge's drop events to the count, clamping at the maximum.
    always_comb begin
        drop_ext_s             = '0;
        drop_ext_s[DEPTH-1:0]  = drop_s;
        drop_sum_s = {1'b0, drop_cnt_r} + {{(DROP_W-5){1'b0}}, hop_popcount(drop_ext_s)};
        if (drop_sum_s > {1'b0, DROP_MAX}) begin
            drop_nxt_s = DROP_MAX;
        end else begin
            drop_nxt_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // Drop counter is owned by the global reset only.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            drop_cnt_r <= '0;
        end else begin
            drop_cnt_r <= drop_nxt_s;
        end
    end

    assign drop_cnt  = drop_cnt_r;
    assign out_valid = stage_v_s[DEPTH-1];
    assign out_data  = stage_d_s[DEPTH-1];

endmodule

// File: tb/tb_hop_pipe_rstdom.sv
// Directed checks of hop_pipe_rstdom: reset, latency, stall, stage reset, drop saturation.
module tb_hop_pipe_rstdom;

    logic       clock0 = 1'b0;
    logic       rst1;
    logic [4:0] rst_stage;
    logic       en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] rst_busy;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       en;
        logic       eov;
        logic [7:0] eod;
    } vec_t;

    vec_t vec [25];

    hop_pipe_rstdom #(
        .WIDTH(8),
        .DEPTH(5),
        .SYNC_STAGES(2)
    ) dut (
        .clock0   (clock0),
        .rst1     (rst1),
        .rst_stage(rst_stage),
        .en       (en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .rst_busy (rst_busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clock0 = ~clock0;

    task automatic step();
        @(posedge clock0);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // latency run
        vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00};
        vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        // stall run: three disabled edges mid-flight
        vec[6]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        vec[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
        vec[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        // back-to-back stream with a bubble whose data still travels
        vec[16] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00};
        vec[17] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00};
        vec[18] = '{1'b0, 8'h33, 1'b1, 1'b0, 8'h00};
        vec[19] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00};
        vec[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11};
        vec[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22};
        vec[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33};
        vec[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44};
        vec[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

        rst1      = 1'b1;
        rst_stage = 5'b00000;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_busy_all", {27'd0, rst_busy}, 32'h1F);

        rst1 = 1'b0;
        step();
        chk("rel_busy_edge1", {27'd0, rst_busy}, 32'h1F);
        step();
        chk("rel_busy_edge2", {27'd0, rst_busy}, 32'h00);

        for (int i = 0; i < 25; i++) begin
            in_valid = vec[i].iv;
            in_data  = vec[i].din;
            en       = vec[i].en;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vec[i].eov});
            chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vec[i].eod});
            chk($sformatf("vec%0d_drop", i), {24'd0, drop_cnt}, 32'd0);
            chk($sformatf("vec%0d_busy", i), {27'd0, rst_busy}, 32'd0);
        end

        // stage reset while 0x3C sits in stage 1
        en = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        step();
        rst_stage = 5'b00100;
        #1;
        chk("srst_busy_immediate", {27'd0, rst_busy}, 32'h04);
        chk("srst_drop_before", {24'd0, drop_cnt}, 32'd0);
        step();
        chk("srst_drop_one", {24'd0, drop_cnt}, 32'd1);
        chk("srst_busy_held", {27'd0, rst_busy}, 32'h04);
        step();
        rst_stage = 5'b00000;
        step();
        chk("srst_rel_edge1", {27'd0, rst_busy}, 32'h04);
        step();
        chk("srst_rel_edge2", {27'd0, rst_busy}, 32'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("srst_no_out%0d", i), {31'd0, out_valid}, 32'd0);
        end
        chk("srst_drop_stable", {24'd0, drop_cnt}, 32'd1);

        // saturation: stage 0 held in reset with a steady input stream
        rst_stage = 5'b00001; in_valid = 1'b1; in_data = 8'h5A; en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 99) chk("sat_drop_100", {24'd0, drop_cnt}, 32'd101);
            if (i == 253) chk("sat_drop_255", {24'd0, drop_cnt}, 32'd255);
        end
        chk("sat_drop_hold", {24'd0, drop_cnt}, 32'd255);
        rst_stage = 5'b00000; in_valid = 1'b0;
        step();
        step();
        step();
        chk("sat_no_stage_clear", {24'd0, drop_cnt}, 32'd255);

        rst1 = 1'b1;
        #1;
        chk("grst_drop_clear", {24'd0, drop_cnt}, 32'd0);
        chk("grst_busy", {27'd0, rst_busy}, 32'h1F);
        chk("grst_out_valid", {31'd0, out_valid}, 32'd0);

        // items offered during the release window are counted as drops
        step();
        in_valid = 1'b1; in_data = 8'h77; en = 1'b1;
        rst1 = 1'b0;
        step();
        chk("win_drop1", {24'd0, drop_cnt}, 32'd1);
        step();
        chk("win_drop2", {24'd0, drop_cnt}, 32'd2);
        chk("win_busy_clear", {27'd0, rst_busy}, 32'h00);
        in_valid = 1'b0;
        step();
        chk("win_drop_stop", {24'd0, drop_cnt}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hop_pipe_rstdom.md
HOP_PIPE_RSTDOM -- requirements
Module: hop_pipe_rstdom

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width per stage, legal range 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 5: number of pipeline stages, legal range 1 to 32.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: reset-release synchroniser length, legal range 2 or more.
REQ-004 The block SHALL have port clock0, input, 1 bit: single clock; all flops on its rising edge.
REQ-005 The block SHALL have port rst1, input, 1 bit: reset, asynchronous, active-high; global.
REQ-006 The block SHALL have port rst_stage, input, DEPTH bits: per-stage asynchronous active-high local reset requests.
REQ-007 The block SHALL have port en, input, 1 bit: pipeline advance enable.
REQ-008 The block SHALL have port in_valid, input, 1 bit: an item is presented to stage 0.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: item payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: valid bit of stage DEPTH-1.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: data of stage DEPTH-1.
REQ-012 The block SHALL have port rst_busy, output, DEPTH bits: bit k high while the effective reset rs_k of stage k is asserted.
REQ-013 The block SHALL have port drop_cnt, output, 8 bits: saturating count of items lost to stage resets.

Function
REQ-014 Effective reset rs_k SHALL be (rst1 OR rst_stage[k]) asserted asynchronously, with release synchronised through SYNC_STAGES clock0 flops.
REQ-015 rs_k SHALL fall on the SYNC_STAGES-th rising edge of clock0 after both sources are low.
REQ-016 Each stage k SHALL hold a valid bit v[k] and a data register d[k], with v[-1]=in_valid and d[-1]=in_data.
REQ-017 While rs_k is high, v[k] and d[k] SHALL be 0.
REQ-018 Otherwise, on an edge with en=1, v[k] SHALL load v[k-1] and d[k] SHALL load d[k-1]; with en=0 both SHALL hold.
REQ-019 Latency in_valid to out_valid SHALL be exactly DEPTH enabled edges, with no stage in reset.
REQ-020 A drop event for stage k SHALL occur on an edge where en=1, v[k-1]=1, rs_k=1 and rst1=0; the item is discarded.
REQ-021 drop_cnt SHALL increase by the number of drop events on that edge and saturate at 255; it never wraps.
REQ-022 Stages not in reset SHALL continue to shift while other stages are in reset; each reset stage inserts a bubble.
REQ-023 Asserting rst_stage[k] mid-flight SHALL clear only stage k; items in stages below k advance into k and drop; items in stages above k are unaffected.
REQ-024 rst_busy SHALL equal the rs vector directly; it is not registered again.
REQ-025 out_valid SHALL equal v[DEPTH-1] and out_data SHALL equal d[DEPTH-1].

Reset
REQ-026 While rst1 is high, all v, d, synchroniser flops and drop_cnt SHALL be 0.
REQ-027 While rst1 is high, out_valid=0, out_data=0, drop_cnt=0 and rst_busy all ones.
REQ-028 drop_cnt SHALL be cleared by rst1 only; rst_stage SHALL NOT affect it.
REQ-029 After rst1 is released, all stages SHALL stay in reset for SYNC_STAGES edges; in_valid items in that window SHALL count as drops.

Structure
REQ-030 Package hop_pkg SHALL hold the default parameter constants and the DROP_W=8 and DROP_MAX=255 constants.
REQ-031 Sub-module hop_rst_sync SHALL implement one asynchronous-assert/synchronous-release synchroniser, parametrised by SYNC_STAGES, instantiated DEPTH times.
REQ-032 The drop popcount and saturating adder SHALL be combinational within hop_pipe_rstdom.

Verification (DEPTH=5, WIDTH=8, SYNC_STAGES=2)
REQ-033 Reset scenario: rst1=1 -> out_valid=0, out_data=0x00, drop_cnt=0, rst_busy=5'b11111; release rst1 -> rst_busy=5'b00000 on the 2nd edge.
REQ-034 Latency scenario: en=1, in_valid=1 with in_data=0xA5 for one cycle -> out_valid=1 with out_data=0xA5 exactly 5 edges later, for one cycle.
REQ-035 Stall scenario: same stimulus with en=0 for 3 cycles mid-flight -> 0xA5 appears at edge 8 and is held, not duplicated.
REQ-036 Stage-reset scenario: item 0x3C in stage 1, assert rst_stage[2] -> rst_busy[2]=1 immediately, next enabled edge drop_cnt=1, item never reaches output; release -> rst_busy[2]=0 on the 2nd edge.
REQ-037 Saturation scenario: rst_stage[0]=1, in_valid=1, en=1 for 300 cycles -> drop_cnt reaches 255 and stays 255; rst_stage[0] alone does not clear it; rst1 does.
